uart_tx_buf: RTL

//   UART transmitter with byte FIFO: 8 data bits, 1 stop bit, no parity, LSB first.

---
 rtl/uart_tx_buf.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buf.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO; queues rising-edge write
// strobes and serialises them back-to-back onto a registered TX pin.
module uart_tx_buf #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_sys_clk,
  input  logic                          i_rst,
  input  logic                          i_send_en,
  input  logic [7:0]                    i_send_data,
  output logic                          o_tx_pin,
  output logic                          o_tx_busy,
  output logic                          o_fifo_empty,
  output logic                          o_fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_drop
);

  localparam int RATE_CNT = (CLK_FRE * 1000000 / UART_RATE) - 1;
  localparam int CNT_W    = (RATE_CNT > 0) ? $clog2(RATE_CNT + 1) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(RATE_CNT);
  localparam logic [AW:0]      DEPTH_C   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]      CNT_ONE   = (AW+1)'(1);
  localparam logic [CNT_W-1:0] CLK_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  // ---------------------------------------------------------------------------
  // Write strobe edge detect; en_d resets high so a level held across reset
  // release is not mistaken for a fresh write.
  // ---------------------------------------------------------------------------
  logic en_d;
  logic wr;
  logic wr_acc;
  logic pop;

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) en_d <= 1'b1;
    else       en_d <= i_send_en;
  end

  assign wr = i_send_en & ~en_d;

  // ---------------------------------------------------------------------------
  // Byte FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt_q;
  logic          empty;
  logic          full;
  logic [7:0]    head;

  assign empty  = (cnt_q == '0);
  assign full   = (cnt_q == DEPTH_C);
  assign head   = mem[rd_ptr];
  // When full, a same-cycle pop frees the slot the write lands in.
  assign wr_acc = wr & (~full | pop);

  always_ff @(posedge i_sys_clk) begin
    if (wr_acc) mem[wr_ptr] <= i_send_data;
  end

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
      o_drop <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
      o_drop <= wr & ~wr_acc;
    end
  end

  assign o_fifo_empty = empty;
  assign o_fifo_full  = full;
  assign o_fifo_cnt   = cnt_q;

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  tx_state_t        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_q, shift_d;
  logic             pin_d;
  logic             bit_end;

  assign bit_end = (clk_cnt_q == RATE_LAST);

  always_ff @(posedge i_sys_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= TX_IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      o_tx_pin  <= 1'b1;
      o_tx_busy <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      o_tx_pin  <= pin_d;
      o_tx_busy <= (state_d != TX_IDLE);
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;
    pin_d     = 1'b1;
    case (state_q)
      TX_IDLE: begin
        pin_d = 1'b1;
        if (!empty) begin
          pop       = 1'b1;
          shift_d   = head;
          clk_cnt_d = '0;
          state_d   = TX_START;
        end
      end
      TX_START: begin
        pin_d = 1'b0;
        if (bit_end) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = TX_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      TX_DATA: begin
        pin_d = shift_q[bit_cnt_q];
        if (bit_end) begin
          clk_cnt_d = '0;
          if (bit_cnt_q == 3'd7) state_d   = TX_STOP;
          else                   bit_cnt_d = bit_cnt_q + 3'd1;
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      TX_STOP: begin
        pin_d = 1'b1;
        if (bit_end) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit so queued frames abut.
          if (!empty) begin
            pop     = 1'b1;
            shift_d = head;
            state_d = TX_START;
          end else begin
            state_d = TX_IDLE;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CLK_ONE;
        end
      end
      default: begin
        state_d = TX_IDLE;
      end
    endcase
  end

endmodule
